target_monitor: RTL and testbench

TARGET_MONITOR -- requirements
Module: target_monitor

---
 rtl/target_monitor_pkg.sv | 15 +
 rtl/target_monitor_sat.sv | 26 ++
 rtl/target_monitor.sv | 157 +++++++++++++++
 tb/tb_target_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/target_monitor_pkg.sv
// target_monitor_pkg: shared types and default constants for target_monitor.
//   state_t    : monitor FSM states (SEARCH waits for an entry, REPORT holds an event)
//   TARGET_DEF : default monitored state code
//   CNT_W_DEF  : default counter width
package target_monitor_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [1:0]  TARGET_DEF = 2'b10;
    localparam int unsigned CNT_W_DEF  = 8;

endpackage

// File: rtl/target_monitor_sat.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (q -> 0)
//   inc     : count up by one, holding at all-ones
//   clr     : synchronous clear, has priority over inc
//   q       : counter value
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/target_monitor.sv
// target_monitor: watches the state code of an upstream FSM and reports
// entries into TARGET as events through a valid/ready handshake.
// Optional feature macro: TGT_MON_STREAK_EN (adds streak_max, monitors a).
//   clock      : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   s          : observed upstream state {s1,s0}
//   a          : upstream FSM input (used only with TGT_MON_STREAK_EN)
//   clear      : synchronous clear of counters, flags and pending event
//   hit        : one-cycle pulse after each entry into TARGET
//   hit_count  : saturating number of entries
//   evt_valid  : an event is pending
//   evt_ready  : consumer accepts the pending event
//   evt_gap    : non-TARGET cycles preceding the reported entry
//   overrun    : sticky, an entry arrived while an event was stalled
//   streak_max : longest run of consecutive a==1 cycles (macro only)
module target_monitor
    import target_monitor_pkg::*;
#(
    parameter logic [1:0]  TARGET = TARGET_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       s,
    input  logic             a,
    input  logic             clear,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_gap,
`ifdef TGT_MON_STREAK_EN
    output logic             overrun,
    output logic [CNT_W-1:0] streak_max
`else
    output logic             overrun
`endif
);

    logic [1:0]       prev_s;
    logic             entry;
    logic [CNT_W-1:0] gap;
    state_t           state, state_nx;
    logic [CNT_W-1:0] evt_gap_nx;
    logic             overrun_nx;

    assign entry = (s == TARGET) && (prev_s != TARGET);

    // Reset value ~TARGET makes TARGET on the first cycle count as an entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            prev_s <= ~TARGET;
        else
            prev_s <= s;
    end

    // An entry implies s==TARGET, so inc and the entry clear never overlap.
    sat_counter #(.W(CNT_W)) u_gap (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (s != TARGET),
        .clr     (clear | entry),
        .q       (gap)
    );

    sat_counter #(.W(CNT_W)) u_hits (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (entry),
        .clr     (clear),
        .q       (hit_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            hit <= 1'b0;
        else
            hit <= entry && !clear;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= SEARCH;
            evt_gap <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            evt_gap <= evt_gap_nx;
            overrun <= overrun_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        evt_gap_nx = evt_gap;
        overrun_nx = overrun;
        if (clear) begin
            state_nx   = SEARCH;
            evt_gap_nx = '0;
            overrun_nx = 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (entry) begin
                        state_nx   = REPORT;
                        evt_gap_nx = gap;
                    end
                end
                REPORT: begin
                    // A new entry while the consumer stalls is dropped; the
                    // pending evt_gap is kept stable.
                    if (entry) begin
                        if (evt_ready)
                            evt_gap_nx = gap;
                        else
                            overrun_nx = 1'b1;
                    end else if (evt_ready) begin
                        state_nx = SEARCH;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    assign evt_valid = (state == REPORT);

`ifdef TGT_MON_STREAK_EN
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_now;

    sat_counter #(.W(CNT_W)) u_run (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (a),
        .clr     (clear | ~a),
        .q       (run)
    );

    // Length of the run including the current cycle, so the maximum
    // tracks a streak while it is still in progress.
    assign run_now = !a ? '0 : ((run == '1) ? run : run + CNT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            streak_max <= '0;
        else if (clear)
            streak_max <= '0;
        else if (run_now > streak_max)
            streak_max <= run_now;
    end
`else
    logic unused_a;
    assign unused_a = a;
`endif

endmodule

// File: tb/tb_target_monitor.sv
module tb_target_monitor;
    import target_monitor_pkg::*;

    localparam int unsigned W    = 4;
    localparam logic [1:0]  TGT  = TARGET_DEF;
    localparam int          MAXV = (1 << W) - 1;

    logic         clock     = 1'b0;
    logic         reset_n   = 1'b0;
    logic [1:0]   s         = 2'b00;
    logic         a         = 1'b0;
    logic         clear     = 1'b0;
    logic         evt_ready = 1'b0;
    logic         hit;
    logic [W-1:0] hit_count;
    logic         evt_valid;
    logic [W-1:0] evt_gap;
    logic         overrun;
`ifdef TGT_MON_STREAK_EN
    logic [W-1:0] streak_max;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [1:0] m_prev;
    int m_gap, m_hits, m_evt_gap, m_cur, m_max;
    bit m_hit, m_valid, m_overrun;

    target_monitor #(.TARGET(TGT), .CNT_W(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .s          (s),
        .a          (a),
        .clear      (clear),
        .hit        (hit),
        .hit_count  (hit_count),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_gap    (evt_gap),
`ifdef TGT_MON_STREAK_EN
        .overrun    (overrun),
        .streak_max (streak_max)
`else
        .overrun    (overrun)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        vectors++;
        if (got !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < MAXV) ? v + 1 : MAXV;
    endfunction

    task automatic mreset();
        m_prev = ~TGT;
        m_gap = 0; m_hits = 0; m_evt_gap = 0; m_cur = 0; m_max = 0;
        m_hit = 0; m_valid = 0; m_overrun = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs at the edge.
    task automatic mstep();
        bit entry;
        entry = (s == TGT) && (m_prev != TGT);
        if (clear) begin
            m_hits = 0; m_gap = 0; m_overrun = 0; m_hit = 0;
            m_evt_gap = 0; m_valid = 0; m_cur = 0; m_max = 0;
        end else begin
            m_hit = entry;
            if (entry) begin
                m_hits = sat_inc(m_hits);
                if (!m_valid || evt_ready) begin
                    m_valid   = 1;
                    m_evt_gap = m_gap;
                end else begin
                    m_overrun = 1;
                end
            end else if (m_valid && evt_ready) begin
                m_valid = 0;
            end
            if (entry)          m_gap = 0;
            else if (s != TGT)  m_gap = sat_inc(m_gap);
            m_cur = a ? sat_inc(m_cur) : 0;
            if (m_cur > m_max) m_max = m_cur;
        end
        m_prev = s;
    endtask

    task automatic check_all();
        chk("hit",       32'(hit),       int'(m_hit));
        chk("hit_count", 32'(hit_count), m_hits);
        chk("evt_valid", 32'(evt_valid), int'(m_valid));
        chk("evt_gap",   32'(evt_gap),   m_evt_gap);
        chk("overrun",   32'(overrun),   int'(m_overrun));
`ifdef TGT_MON_STREAK_EN
        chk("streak_max", 32'(streak_max), m_max);
`endif
    endtask

    // Called at a falling edge; applies inputs for one rising edge.
    task automatic cyc(input logic [1:0] si, input logic ai, input logic ci, input logic ri);
        s = si; a = ai; clear = ci; evt_ready = ri;
        @(posedge clock);
        mstep();
        @(negedge clock);
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        mreset();
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        do_reset();

        // Entry on the very first cycle after reset
        cyc(TGT, 1'b0, 1'b0, 1'b0);
        chk("first_hit",   32'(hit), 1);
        chk("first_count", 32'(hit_count), 1);
        chk("first_valid", 32'(evt_valid), 1);
        chk("first_gap",   32'(evt_gap), 0);

        // Three non-target cycles, then entry, consumer always ready
        cyc(2'b00, 1'b0, 1'b0, 1'b1);
        cyc(2'b01, 1'b0, 1'b0, 1'b1);
        cyc(2'b11, 1'b0, 1'b0, 1'b1);
        cyc(TGT,   1'b0, 1'b0, 1'b1);
        chk("gap3_value", 32'(evt_gap), 3);
        chk("gap3_valid", 32'(evt_valid), 1);
        cyc(TGT,   1'b0, 1'b0, 1'b1);
        chk("gap3_search", 32'(evt_valid), 0);

        // Entry accepted in the same cycle as a pending event
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(TGT,   1'b0, 1'b0, 1'b0);
        repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(TGT,   1'b0, 1'b0, 1'b1);
        chk("reload_valid",   32'(evt_valid), 1);
        chk("reload_gap",     32'(evt_gap), 3);
        chk("reload_overrun", 32'(overrun), 0);

        // Two entries with a stalled consumer
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(TGT,   1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(TGT,   1'b0, 1'b0, 1'b0);
        chk("ovr_flag",  32'(overrun), 1);
        chk("ovr_count", 32'(hit_count), 2);
        chk("ovr_gap",   32'(evt_gap), 2);

        // Clear coinciding with an entry, then a streak of a
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(TGT,   1'b0, 1'b1, 1'b0);
        chk("clr_count", 32'(hit_count), 0);
        chk("clr_valid", 32'(evt_valid), 0);
        chk("clr_hit",   32'(hit), 0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
`ifdef TGT_MON_STREAK_EN
        chk("streak_3", 32'(streak_max), 3);
`endif

        // Saturation of hit_count and of the gap counter
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        repeat (20) begin
            cyc(2'b00, 1'b0, 1'b0, 1'b1);
            cyc(TGT,   1'b0, 1'b0, 1'b1);
        end
        chk("sat_count", 32'(hit_count), 15);
        repeat (300) cyc(2'b00, 1'b0, 1'b0, 1'b1);
        cyc(TGT, 1'b0, 1'b0, 1'b0);
        chk("sat_gap", 32'(evt_gap), 15);

        // Reset while an event is pending
        do_reset();
        chk("rst_overrun", 32'(overrun), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 99) < 45) ? TGT : 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 99) < 70),
                    1'($urandom_range(0, 99) < 3),
                    1'($urandom_range(0, 99) < 50));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
